// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: pad synchronisers, PS2_CLK deglitch filter,
// 11-bit frame deserialiser with parity/framing checks and a scan-code FIFO.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       SCAN_READY,
  input  logic       CLR_OVF,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]       clk_sync, data_sync;
  logic             filt_clk, strobe, data_bit;
  logic [3:0]       filt_cnt;
  state_t           state, state_next;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit, push_req, perr_set, ferr_set;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, full, push_ok, ovf_evt;

  assign data_bit = data_sync[1];

  // The filtered clock only follows the pad after FILTER_LEN consecutive
  // disagreeing samples; the strobe marks a filtered 1->0 transition.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      strobe    <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        strobe   <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    push_req    = 1'b0;
    perr_set    = 1'b0;
    ferr_set    = 1'b0;
    timeout_hit = (state != IDLE) && !strobe && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    if (timeout_hit) begin
      ferr_set   = 1'b1;
      state_next = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE:   if (!data_bit) state_next = DATA;
        DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          state_next = IDLE;
          // A bad stop bit outranks a parity failure.
          if (!data_bit)                     ferr_set = 1'b1;
          else if (!(^{shift_reg, parity_bit})) perr_set = 1'b1;
          else                               push_req = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= state_next;
      PARITY_ERR <= perr_set;
      FRAME_ERR  <= ferr_set;
      if (state == IDLE || strobe || timeout_hit) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + TO_W'(1);
      if (strobe) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          PARITY:  parity_bit <= data_bit;
          default: ;
        endcase
      end
    end
  end

  // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
  assign pop        = SCAN_VALID && SCAN_READY;
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_req && (!full || pop);
  assign ovf_evt    = push_req && full && !pop;
  assign SCAN_VALID = (count != '0);
  assign SCAN_CODE  = SCAN_VALID ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge FAB_CLK) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push_ok) count <= count - CNT_W'(1);
      if (ovf_evt)      OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: table of frames plus hand-written
// glitch, timeout, overflow and reset sequences, with a scan-code scoreboard.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 500;
  localparam int DEPTH      = 4;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       scan_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] scan_code;
  logic       scan_valid, parity_err, frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic       stop;
    int         glitch;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_push;
  } vec_t;
  vec_t vecs[8];

  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .FAB_CLK(clk), .RESET(reset), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .SCAN_READY(scan_ready), .CLR_OVF(clr_ovf), .SCAN_CODE(scan_code),
    .SCAN_VALID(scan_valid), .PARITY_ERR(parity_err), .FRAME_ERR(frame_err),
    .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Send nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic applyStimulus(input logic [7:0] d, input logic par_bad, input logic stop,
                               input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, ~(^d) ^ par_bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF / 2);
      if (i == glitch_bit) begin
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
      end
      tick(HALF / 2);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  // Model of a good frame arriving at the FIFO (no concurrent reads).
  task automatic modelPush(input logic [7:0] d, output logic ovf);
    ovf = 1'b0;
    if (model_count < DEPTH) begin
      exp_q.push_back(d);
      model_count++;
    end else begin
      ovf = 1'b1;
    end
  endtask

  task automatic popCheck(input string name);
    int waited;
    logic [7:0] exp;
    waited = 0;
    while (!scan_valid && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!scan_valid) begin
      checkOutput({name, "_valid_timeout"}, 32'(scan_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      checkOutput({name, "_unexpected"}, 32'(scan_code), 32'hFFFF_FFFF);
    end else begin
      exp = exp_q.pop_front();
      model_count--;
      checkOutput(name, 32'(scan_code), 32'(exp));
      scan_ready = 1'b1;
      tick(1);
      scan_ready = 1'b0;
    end
  endtask

  initial begin
    int p0, f0;
    logic ovf_exp;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h1C, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h29, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h1C, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b1};

    tick(3);
    checkOutput("reset_valid", 32'(scan_valid), 32'd0);
    checkOutput("reset_code", 32'(scan_code), 32'd0);
    checkOutput("reset_perr", 32'(parity_err), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 8; i++) begin
      p0 = perr_cnt;
      f0 = ferr_cnt;
      applyStimulus(vecs[i].data, vecs[i].par_bad, vecs[i].stop, 11, vecs[i].glitch);
      tick(2);
      checkOutput($sformatf("vec%0d_perr", i), 32'(perr_cnt - p0), 32'(vecs[i].exp_perr));
      checkOutput($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_valid", i), 32'(scan_valid), 32'(vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        modelPush(vecs[i].data, ovf_exp);
        popCheck($sformatf("vec%0d_code", i));
        checkOutput($sformatf("vec%0d_drained", i), 32'(scan_valid), 32'd0);
      end
    end

    // Low glitch on PS2_CLK while idle with data low must not start a frame.
    p0 = perr_cnt;
    f0 = ferr_cnt;
    ps2_data = 1'b0;
    tick(2);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(4);
    ps2_data = 1'b1;
    tick(10);
    applyStimulus(8'h29, 1'b0, 1'b1, 11, -1);
    tick(2);
    checkOutput("idle_glitch_errs", 32'((perr_cnt - p0) + (ferr_cnt - f0)), 32'd0);
    modelPush(8'h29, ovf_exp);
    popCheck("idle_glitch_code");

    // Timeout after start + 4 data bits.
    f0 = ferr_cnt;
    applyStimulus(8'h0F, 1'b0, 1'b1, 5, -1);
    tick(TIMEOUT - 70);
    checkOutput("timeout_early", 32'(ferr_cnt - f0), 32'd0);
    tick(80);
    checkOutput("timeout_ferr", 32'(ferr_cnt - f0), 32'd1);
    checkOutput("timeout_valid", 32'(scan_valid), 32'd0);
    applyStimulus(8'h5A, 1'b0, 1'b1, 11, -1);
    tick(2);
    modelPush(8'h5A, ovf_exp);
    popCheck("after_timeout_code");

    // Overflow: five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b1, 11, -1);
      modelPush(8'(i), ovf_exp);
    end
    tick(2);
    checkOutput("overflow_set", 32'(overflow), 32'(ovf_exp));
    for (int i = 1; i <= 4; i++) popCheck($sformatf("ovf_read%0d", i));
    checkOutput("ovf_empty", 32'(scan_valid), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-frame with a byte already buffered.
    applyStimulus(8'h33, 1'b0, 1'b1, 11, -1);
    applyStimulus(8'h1C, 1'b0, 1'b1, 7, -1);
    p0 = perr_cnt;
    f0 = ferr_cnt;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    exp_q.delete();
    model_count = 0;
    checkOutput("midreset_valid", 32'(scan_valid), 32'd0);
    checkOutput("midreset_code", 32'(scan_code), 32'd0);
    checkOutput("midreset_ovf", 32'(overflow), 32'd0);
    tick(TIMEOUT + 20);
    checkOutput("midreset_noerr", 32'((perr_cnt - p0) + (ferr_cnt - f0)), 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);
    tick(2);
    modelPush(8'h1C, ovf_exp);
    popCheck("after_reset_code");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Fabric-side PS/2 receiver clocked by the fabric clock that the MSS clock-conditioning stage generates from the on-chip RC oscillator.
- Synchronises and deglitches the external PS2_CLK/PS2_DATA pads, deserialises 11-bit device-to-host frames and checks odd parity and framing.
- Buffers good scan codes in a small FIFO behind a valid/ready interface for the keyboard decoder of the tank game logic.

Parameters:
- FILTER_LEN, 8, consecutive identical PS2_CLK samples needed before the filtered clock changes (range 2..15).
- TIMEOUT_CYCLES, 50000, FAB_CLK cycles without a filtered falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, 4, scan-code buffer entries (power of 2, 2..16).

Ports:
- FAB_CLK  in  1  fabric clock; the only clock in the block.
- RESET  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  asynchronous PS/2 clock pad input.
- PS2_DATA  in  1  asynchronous PS/2 data pad input.
- SCAN_READY  in  1  consumer accepts the head entry.
- CLR_OVF  in  1  clears OVERFLOW; single-cycle pulse.
- SCAN_CODE  out  8  FIFO head byte; 0x00 when empty.
- SCAN_VALID  out  1  FIFO not empty.
- PARITY_ERR  out  1  one-cycle pulse; frame dropped for bad parity.
- FRAME_ERR  out  1  one-cycle pulse; frame dropped for bad stop bit or timeout.
- OVERFLOW  out  1  sticky; good frame lost because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, filtered clock 1, synchronisers 1, timeout counter 0. RESET mid-frame discards the partial frame and produces no error pulse.
- Synchronisation: each pad passes through a 2-FF synchroniser.
- Clock filter: the filtered clock takes the synchronised value after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock produces a one-cycle sample strobe, and synchronised PS2_DATA is captured on that strobe.
- FSM states:
  - IDLE: on a strobe, data=0 moves to DATA with bit count 0; data=1 is ignored and the FSM stays in IDLE.
  - DATA: shifts the byte in LSB first. After the 8th strobe it moves to PARITY.
  - PARITY: captures the parity bit and moves to STOP.
  - STOP: captures the stop bit and returns to IDLE.
- Stop-bit evaluation, in priority order:
  - stop=0: FRAME_ERR pulse, frame dropped.
  - otherwise, XOR of the 8 data bits and the parity bit equal to 0 (even count): PARITY_ERR pulse, frame dropped.
  - otherwise, the byte is pushed into the FIFO.
- Error pulse and push timing: both occur on the clock edge after the stop strobe. SCAN_VALID is high from that edge if the FIFO was empty.
- Timeout: the counter clears on every strobe and in IDLE, and increments in every other state. When it reaches TIMEOUT_CYCLES: FRAME_ERR pulse, FSM to IDLE, counter cleared.
- FIFO read/write:
  - Pop when SCAN_VALID && SCAN_READY; SCAN_CODE updates to the next entry on the following edge.
  - Push to a full FIFO is dropped and sets OVERFLOW, unless a pop occurs in the same cycle. In that case both happen and the occupancy stays FIFO_DEPTH.
  - Push and pop together on an empty FIFO are impossible (SCAN_VALID=0); the push is accepted.
  - Read and write pointers wrap modulo FIFO_DEPTH, using an occupancy counter of width log2(FIFO_DEPTH)+1.
- OVERFLOW flag: cleared by CLR_OVF. When CLR_OVF coincides with a new overflow event, OVERFLOW stays set.
- Ordering: at most one of PARITY_ERR and FRAME_ERR is asserted per frame.

Test Plan:
- Good frame 0x1C: bits 0,0,0,1,1,1,0,0,0,0(parity),1 at 12.5 kHz with READY=0 -> SCAN_VALID=1, SCAN_CODE=0x1C, no error pulses. Assert READY for 1 cycle -> SCAN_VALID=0.
- Parity error: 0x1C sent with parity bit 1 -> one PARITY_ERR pulse, SCAN_VALID stays 0. Then a good 0xF0 (parity 1) -> SCAN_CODE=0xF0.
- Glitch rejection: inject a 3-cycle low pulse on PS2_CLK while idle and a 3-cycle pulse mid-frame -> no strobe, no bit shift. A subsequent frame of 0x29 is received correctly.
- Timeout: send start bit plus 4 data bits, then hold PS2_CLK high for 50000 cycles -> FRAME_ERR pulse exactly at count 50000, FSM in IDLE. A following 0x5A frame is received.
- Bad stop bit: 0x1C with correct parity and stop=0 -> FRAME_ERR only, not PARITY_ERR.
- Overflow and reset:
  - 5 good frames 0x01..0x05 with READY=0 -> OVERFLOW=1; reads return 0x01..0x04 in order.
  - CLR_OVF -> OVERFLOW=0.
  - RESET asserted after bit 6 of a frame -> all outputs 0; the next full 0x1C frame is received.
